// File: rtl/fetch_pkg.sv
// Shared types and widths for the dmem fetch buffer and its FIFO.
package fetch_pkg;

    localparam int FETCH_ADDR_W = 7;
    localparam int FETCH_DATA_W = 64;

    typedef logic [FETCH_DATA_W-1:0] act_word_t;

    // Number of reads in flight; the valid pipe is at most two stages deep.
    function automatic logic [1:0] count_inflight(input logic [1:0] vpipe);
        return {1'b0, vpipe[0]} + {1'b0, vpipe[1]};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH x DATA_W register FIFO; full/empty come from the entry count, not pointer equality.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic                       not_empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_pop_s;

    // Next-state for storage, pointers and count; flush wins over push and pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop_s = pop && (count_q != CNT_W'(0));
        if (flush) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; its contents are only observed behind a non-zero count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata     = mem_q[rd_ptr_q];
    assign not_empty = (count_q != CNT_W'(0));
    assign count     = count_q;

endmodule

// File: rtl/dmem_fetch_buf.sv
// Credit-based dmem read issue with a return FIFO toward the popcount array.
// Optional FETCH_STALL_CNT_EN adds a saturating consumer-stall counter output.
module dmem_fetch_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = 4,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   addr_valid,
    input  logic [ADDR_W-1:0]      addr,
    output logic                   addr_ready,
    output logic                   dmem_re,
    output logic [ADDR_W-1:0]      dmem_raddr,
    input  logic [DATA_W-1:0]      dmem_rdata,
    output logic                   act_valid,
    output logic [DATA_W-1:0]      act_data,
    input  logic                   act_ready,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef FETCH_STALL_CNT_EN
   ,output logic [15:0]            stall_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [RD_LAT-1:0] vpipe_q, vpipe_d;
    logic [RD_LAT:0]   vshift_s;
    logic [1:0]        inflight_s;
    logic [CNT_W:0]    used_s;
    logic [CNT_W-1:0]  count_s;
    logic              fire_s;
    logic              push_s;
    logic              pop_s;

    // Credit check and same-cycle read issue; a pop this cycle does not return a credit.
    always_comb begin
        inflight_s = count_inflight(2'(vpipe_q));
        used_s     = (CNT_W+1)'(count_s) + (CNT_W+1)'(inflight_s);
        addr_ready = !flush && (used_s < (CNT_W+1)'(DEPTH));
        fire_s     = addr_valid && addr_ready;
        dmem_re    = fire_s;
        if (fire_s) begin
            dmem_raddr = addr;
        end else begin
            dmem_raddr = ADDR_W'(0);
        end
    end

    // The valid pipe tracks reads until their data lands on dmem_rdata.
    always_comb begin
        vshift_s = {vpipe_q, fire_s};
        if (flush) begin
            vpipe_d = RD_LAT'(0);
        end else begin
            vpipe_d = vshift_s[RD_LAT-1:0];
        end
        push_s = vpipe_q[RD_LAT-1] && !flush;
        pop_s  = act_valid && act_ready;
    end

    // Valid pipe register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vpipe_q <= RD_LAT'(0);
        end else begin
            vpipe_q <= vpipe_d;
        end
    end

    fetch_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push_s),
        .wdata     (dmem_rdata),
        .pop       (pop_s),
        .rdata     (act_data),
        .not_empty (act_valid),
        .count     (count_s)
    );

    assign occupancy = count_s;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a word waits on the consumer, saturating at all-ones.
    always_comb begin
        if (flush) begin
            stall_cnt_d = 16'h0000;
        end else if (act_valid && !act_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'h0001;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_fetch_buf.sv
// Self-checking bench for dmem_fetch_buf (DEPTH=4, RD_LAT=1) with a data scoreboard.
module tb_dmem_fetch_buf;
    import fetch_pkg::*;

    logic       clk = 1'b0;
    logic       rst, flush, addr_valid, act_ready;
    logic [6:0] addr;
    logic       addr_ready, dmem_re, act_valid;
    logic [6:0] dmem_raddr;
    logic [63:0] dmem_rdata = 64'd0;
    logic [63:0] act_data;
    logic [2:0] occupancy;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    act_word_t sb[$];

    typedef struct {
        logic       av;
        logic [6:0] a;
        logic       ar;
        logic       exp_rdy;
        logic       exp_av;
        logic [2:0] exp_occ;
    } vec_t;
    vec_t tbl[14];

    dmem_fetch_buf dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .addr_valid (addr_valid),
        .addr       (addr),
        .addr_ready (addr_ready),
        .dmem_re    (dmem_re),
        .dmem_raddr (dmem_raddr),
        .dmem_rdata (dmem_rdata),
        .act_valid  (act_valid),
        .act_data   (act_data),
        .act_ready  (act_ready),
        .occupancy  (occupancy)
`ifdef FETCH_STALL_CNT_EN
       ,.stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous memory model, one-cycle latency, word = address * 3.
    always @(posedge clk) begin
        if (dmem_re) dmem_rdata <= 64'(dmem_raddr) * 64'd3;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected word queued on accept, compared on pop.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb.delete();
        end else begin
            if (act_valid && act_ready) begin
                if (sb.size() == 0) begin
                    check("pop_without_accept", 64'd1, 64'd0);
                end else begin
                    check("sb_data", act_data, sb.pop_front());
                end
            end
            if (addr_valid && addr_ready) sb.push_back(64'(addr) * 64'd3);
            check("occ_le_depth", 64'(occupancy > 3'd4), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int budget;

        tbl[0]  = '{1'b1, 7'd20, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[1]  = '{1'b1, 7'd21, 1'b0, 1'b1, 1'b0, 3'd0};
        tbl[2]  = '{1'b1, 7'd22, 1'b0, 1'b1, 1'b1, 3'd1};
        tbl[3]  = '{1'b1, 7'd23, 1'b0, 1'b1, 1'b1, 3'd2};
        tbl[4]  = '{1'b1, 7'd24, 1'b0, 1'b0, 1'b1, 3'd3};
        tbl[5]  = '{1'b1, 7'd24, 1'b0, 1'b0, 1'b1, 3'd4};
        tbl[6]  = '{1'b1, 7'd24, 1'b1, 1'b0, 1'b1, 3'd4};
        tbl[7]  = '{1'b1, 7'd24, 1'b1, 1'b1, 1'b1, 3'd3};
        tbl[8]  = '{1'b1, 7'd25, 1'b1, 1'b1, 1'b1, 3'd2};
        tbl[9]  = '{1'b1, 7'd26, 1'b1, 1'b1, 1'b1, 3'd2};
        tbl[10] = '{1'b0, 7'd0,  1'b1, 1'b1, 1'b1, 3'd2};
        tbl[11] = '{1'b0, 7'd0,  1'b1, 1'b1, 1'b1, 3'd2};
        tbl[12] = '{1'b0, 7'd0,  1'b1, 1'b1, 1'b1, 3'd1};
        tbl[13] = '{1'b0, 7'd0,  1'b1, 1'b1, 1'b0, 3'd0};

        rst = 1'b1; flush = 1'b0; addr_valid = 1'b0; addr = 7'd0; act_ready = 1'b0;

        // Reset held for two clocks.
        for (int i = 0; i < 2; i++) begin
            step();
            @(negedge clk);
            check("rst_act_valid", 64'(act_valid), 64'd0);
            check("rst_occupancy", 64'(occupancy), 64'd0);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_addr_ready", 64'(addr_ready), 64'd1);

        // Streaming 0..9 with the consumer always ready.
        for (int i = 0; i < 13; i++) begin
            step();
            addr_valid = (i < 10);
            addr       = (i < 10) ? 7'(i) : 7'd0;
            act_ready  = 1'b1;
            @(negedge clk);
            check("stream_act_valid", 64'(act_valid), 64'((i >= 2) && (i <= 11)));
            if (i < 10) check("stream_addr_ready", 64'(addr_ready), 64'd1);
        end

        // Backpressure and release, table driven.
        for (int i = 0; i < 14; i++) begin
            step();
            addr_valid = tbl[i].av;
            addr       = tbl[i].a;
            act_ready  = tbl[i].ar;
            @(negedge clk);
            check("tbl_addr_ready", 64'(addr_ready), 64'(tbl[i].exp_rdy));
            check("tbl_act_valid",  64'(act_valid),  64'(tbl[i].exp_av));
            check("tbl_occupancy",  64'(occupancy),  64'(tbl[i].exp_occ));
        end

        // Flush with three entries held and one read in flight.
        for (int i = 0; i < 4; i++) begin
            step();
            addr_valid = 1'b1;
            addr       = 7'(60 + i);
            act_ready  = 1'b0;
        end
        step();
        flush = 1'b1; addr_valid = 1'b1; addr = 7'd64; act_ready = 1'b1;
        @(negedge clk);
        check("flush_addr_ready", 64'(addr_ready), 64'd0);
        check("flush_dmem_re",    64'(dmem_re),    64'd0);
        check("flush_pre_occ",    64'(occupancy),  64'd3);
        step();
        flush = 1'b0; addr_valid = 1'b0; act_ready = 1'b0;
        @(negedge clk);
        check("post_flush_occ",   64'(occupancy),  64'd0);
        check("post_flush_valid", 64'(act_valid),  64'd0);
        check("post_flush_ready", 64'(addr_ready), 64'd1);
        step();
        addr_valid = 1'b1; addr = 7'd50;
        step();
        addr_valid = 1'b0;
        step();
        @(negedge clk);
        check("post_flush_av",   64'(act_valid), 64'd1);
        check("post_flush_data", act_data, 64'd150);
        step();
        act_ready = 1'b1;
        step();
        @(negedge clk);
        check("post_flush_drained", 64'(act_valid), 64'd0);

        // Wrap: twelve words through with a random consumer.
        accepted = 0;
        budget   = 0;
        while (accepted < 12 && budget < 300) begin
            step();
            addr_valid = 1'b1;
            addr       = 7'(100 + accepted);
            act_ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (addr_ready) accepted++;
            budget++;
        end
        check("wrap_accepts_in_budget", 64'(accepted), 64'd12);
        step();
        addr_valid = 1'b0; act_ready = 1'b1;
        budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            step();
            budget++;
        end
        check("wrap_sb_empty", 64'(sb.size()), 64'd0);
        step();
        @(negedge clk);
        check("wrap_end_valid", 64'(act_valid), 64'd0);
        check("wrap_end_occ",   64'(occupancy), 64'd0);

`ifdef FETCH_STALL_CNT_EN
        // Stall counter: ten waiting cycles, then cleared by flush.
        step();
        flush = 1'b1; act_ready = 1'b0;
        step();
        flush = 1'b0; addr_valid = 1'b1; addr = 7'd70;
        step();
        addr_valid = 1'b0;
        budget = 0;
        @(negedge clk);
        while (!act_valid && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        check("stall_av_seen", 64'(act_valid), 64'd1);
        check("stall_start",   64'(stall_cnt), 64'd0);
        repeat (10) @(posedge clk);
        #1;
        act_ready = 1'b1;
        @(negedge clk);
        check("stall_ten", 64'(stall_cnt), 64'd10);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        @(negedge clk);
        check("stall_flushed", 64'(stall_cnt), 64'd0);
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
